// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to
// instruction memory, then releases the core reset after a fixed settling delay.
module imem_loader #(
   parameter int ADDR_W      = 10,
   parameter int MAX_WORDS   = 1024,
   parameter int RELEASE_DLY = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W:0]   len_words,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_reset_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RECV  = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic [ADDR_W:0] MAX_LEN   = (ADDR_W+1)'(MAX_WORDS);
   localparam logic [ADDR_W:0] ZERO_LEN  = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] ONE_LEN   = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [7:0]      HOLD_LAST = 8'(RELEASE_DLY - 1);

   logic [2:0]        state_r,    state_nx;
   logic [ADDR_W:0]   len_r,      len_nx;
   logic [ADDR_W:0]   word_cnt_r, word_cnt_nx;
   logic [1:0]        byte_cnt_r, byte_cnt_nx;
   logic [31:0]       word_r,     word_nx;
   logic [7:0]        hold_cnt_r, hold_cnt_nx;
   logic              err_r,      err_nx;
   logic              start_ok_s;

   logic              s_ready_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [31:0]       mem_wdata_r;
   logic              core_reset_n_r;
   logic              busy_r;
   logic              done_r;

   // Next-state logic: start acceptance, byte assembly, word stepping and release delay.
   always_comb begin
      state_nx    = state_r;
      len_nx      = len_r;
      word_cnt_nx = word_cnt_r;
      byte_cnt_nx = byte_cnt_r;
      word_nx     = word_r;
      hold_cnt_nx = hold_cnt_r;
      err_nx      = err_r;
      start_ok_s  = (len_words != ZERO_LEN) && (len_words <= MAX_LEN);

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               if (start_ok_s) begin
                  state_nx    = ST_RECV;
                  len_nx      = len_words;
                  word_cnt_nx = ZERO_LEN;
                  byte_cnt_nx = 2'd0;
                  word_nx     = 32'h0000_0000;
                  err_nx      = 1'b0;
               end else begin
                  state_nx = ST_IDLE;
                  err_nx   = 1'b1;
               end
            end else begin
               state_nx = state_r;
            end
         end
         ST_RECV: begin
            if (s_valid) begin
               // Shift in from the top so the first byte ends up in bits 7:0.
               word_nx     = {s_data, word_r[31:8]};
               byte_cnt_nx = byte_cnt_r + 2'd1;
               if (byte_cnt_r == 2'd3) begin
                  state_nx = ST_WRITE;
               end else begin
                  state_nx = ST_RECV;
               end
            end else begin
               state_nx = ST_RECV;
            end
         end
         ST_WRITE: begin
            word_cnt_nx = word_cnt_r + ONE_LEN;
            byte_cnt_nx = 2'd0;
            hold_cnt_nx = 8'd0;
            if (word_cnt_nx == len_r) begin
               state_nx = ST_HOLD;
            end else begin
               state_nx = ST_RECV;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_nx = ST_DONE;
            end else begin
               hold_cnt_nx = hold_cnt_r + 8'd1;
               state_nx    = ST_HOLD;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State, counters and registered outputs (outputs decoded from the next state).
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         len_r          <= ZERO_LEN;
         word_cnt_r     <= ZERO_LEN;
         byte_cnt_r     <= 2'd0;
         word_r         <= 32'h0000_0000;
         hold_cnt_r     <= 8'd0;
         err_r          <= 1'b0;
         s_ready_r      <= 1'b0;
         mem_we_r       <= 1'b0;
         mem_addr_r     <= {ADDR_W{1'b0}};
         mem_wdata_r    <= 32'h0000_0000;
         core_reset_n_r <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
      end else begin
         state_r        <= state_nx;
         len_r          <= len_nx;
         word_cnt_r     <= word_cnt_nx;
         byte_cnt_r     <= byte_cnt_nx;
         word_r         <= word_nx;
         hold_cnt_r     <= hold_cnt_nx;
         err_r          <= err_nx;
         s_ready_r      <= (state_nx == ST_RECV);
         mem_we_r       <= (state_nx == ST_WRITE);
         mem_addr_r     <= word_cnt_nx[ADDR_W-1:0];
         mem_wdata_r    <= word_nx;
         core_reset_n_r <= (state_nx == ST_DONE);
         busy_r         <= (state_nx == ST_RECV) || (state_nx == ST_WRITE) || (state_nx == ST_HOLD);
         done_r         <= (state_nx == ST_DONE);
      end
   end

   assign s_ready      = s_ready_r;
   assign mem_we       = mem_we_r;
   assign mem_addr     = mem_addr_r;
   assign mem_wdata    = mem_wdata_r;
   assign core_reset_n = core_reset_n_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign err          = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: expected memory contents are built from the
// byte stream by plain little-endian grouping and compared with the writes the DUT issues.
module tb_imem_loader;

   localparam int ADDR_W      = 10;
   localparam int MAX_WORDS   = 1024;
   localparam int RELEASE_DLY = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic [ADDR_W:0]   len_words;
   logic              s_valid;
   logic [7:0]        s_data;
   logic              s_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              core_reset_n;
   logic              busy;
   logic              done;
   logic              err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_we_cyc = 0;
   int rise_cyc = 0;
   logic prev_crn = 1'b0;
   int wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0] bytes_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS), .RELEASE_DLY(RELEASE_DLY)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .len_words(len_words),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_reset_n(core_reset_n), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Write logger and core-reset rise tracker, sampled mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wa_q.push_back(int'(mem_addr));
         wd_q.push_back(mem_wdata);
         last_we_cyc <= cyc;
      end
      if (core_reset_n === 1'b1 && prev_crn === 1'b0) rise_cyc <= cyc;
      prev_crn <= core_reset_n;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_random(input int nwords);
      bytes_q.delete();
      for (int i = 0; i < 4 * nwords; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ctl"}, {58'd0, s_ready, mem_we, core_reset_n, busy, done, err}, 64'd0);
      check({tag, "_addr"}, {54'd0, mem_addr}, 64'd0);
      check({tag, "_wdata"}, {32'd0, mem_wdata}, 64'd0);
   endtask

   // mode: 0 valid always high, 1 valid toggles, 2 random valid, 3 long stall mid-word.
   // poke_idx >= 0 asserts start (with a different length) while that byte is pending.
   task automatic run_load(input int len, input int mode, input int poke_idx);
      int idx = 0;
      int budget = 16 * len * 4 + 200;
      int hold_left = 40;
      int n = 4 * len;
      bit v = 1'b0;
      bit busy_bad = 1'b0;
      logic [31:0] exp_w;
      @(negedge clk);
      wa_q.delete();
      wd_q.delete();
      s_valid = 1'b0;
      start = 1'b1;
      len_words = (ADDR_W+1)'(len);
      @(negedge clk);
      start = 1'b0;
      check("accept_crn", {63'd0, core_reset_n}, 64'd0);
      check("accept_err", {63'd0, err}, 64'd0);
      check("accept_ready", {62'd0, busy, s_ready}, 64'd3);
      while (idx < n && budget > 0) begin
         case (mode)
            0: v = 1'b1;
            1: v = ~v;
            2: v = 1'($urandom_range(0, 1));
            default: begin
               if (idx == 2 && hold_left > 0) begin
                  v = 1'b0;
                  hold_left--;
               end else begin
                  v = 1'b1;
               end
            end
         endcase
         s_valid = v;
         s_data = bytes_q[idx];
         if (poke_idx == idx) begin
            start = 1'b1;
            len_words = (ADDR_W+1)'(len + 3);
         end else begin
            start = 1'b0;
         end
         if (busy !== 1'b1) busy_bad = 1'b1;
         if (v && s_ready === 1'b1) idx++;
         budget--;
         @(negedge clk);
      end
      s_valid = 1'b0;
      start = 1'b0;
      check("feed_bytes", 64'(idx), 64'(n));
      budget = RELEASE_DLY + 20;
      while (done !== 1'b1 && budget > 0) begin
         if (busy !== 1'b1) busy_bad = 1'b1;
         @(negedge clk);
         budget--;
      end
      check("done", {63'd0, done}, 64'd1);
      check("busy_throughout", {63'd0, busy_bad}, 64'd0);
      @(negedge clk);
      check("released", {61'd0, core_reset_n, busy, err}, 64'h4);
      // Core reset goes high RELEASE_DLY edges after the edge that ends the last write cycle.
      check("release_dly", 64'(rise_cyc - last_we_cyc), 64'(RELEASE_DLY + 1));
      check("wr_count", 64'(wa_q.size()), 64'(len));
      for (int i = 0; i < len && i < wa_q.size(); i++) begin
         exp_w = {bytes_q[4*i+3], bytes_q[4*i+2], bytes_q[4*i+1], bytes_q[4*i]};
         check("wr_addr", 64'(wa_q[i]), 64'(i));
         check("wr_data", {32'd0, wd_q[i]}, {32'd0, exp_w});
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start = 1'b0;
      len_words = '0;
      s_valid = 1'b0;
      s_data = 8'h00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      check_reset_outputs("reset");

      // Reference load, then the same bytes under toggling valid.
      bytes_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h08, 8'hD0, 8'h05};
      run_load(2, 0, -1);
      check("ref_word0", {32'd0, wd_q[0]}, 64'h0000_0513);
      check("ref_word1", {32'd0, wd_q[1]}, 64'h05D0_0893);
      run_load(2, 1, -1);

      // Length errors from DONE and from IDLE.
      wa_q.delete();
      start = 1'b1;
      len_words = '0;
      @(negedge clk);
      start = 1'b0;
      check("len0_state", {58'd0, s_ready, mem_we, core_reset_n, busy, done, err}, 64'h1);
      @(negedge clk);
      start = 1'b1;
      len_words = (ADDR_W+1)'(MAX_WORDS + 1);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("len_over_state", {58'd0, s_ready, mem_we, core_reset_n, busy, done, err}, 64'h1);
      check("len_err_nowrite", 64'(wa_q.size()), 64'd0);
      fill_random(1);
      run_load(1, 0, -1);

      // Reset after three bytes of a word.
      fill_random(2);
      @(negedge clk);
      wa_q.delete();
      start = 1'b1;
      len_words = (ADDR_W+1)'(2);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1;
         s_data = bytes_q[i];
         @(negedge clk);
      end
      s_valid = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check_reset_outputs("midword_reset");
      repeat (4) @(negedge clk);
      check("midword_nowrite", 64'(wa_q.size()), 64'd0);
      fill_random(1);
      run_load(1, 0, -1);

      // Start pulsed during RECV is ignored; then a restart from DONE.
      fill_random(2);
      run_load(2, 2, 5);
      fill_random(1);
      run_load(1, 0, -1);

      // Random loads, including an indefinite-looking stall mid-word.
      for (int k = 0; k < 4; k++) begin
         int len = $urandom_range(1, 8);
         fill_random(len);
         run_load(len, (k == 3) ? 3 : int'($urandom_range(0, 2)), -1);
      end

      // Largest legal length: writes the final address and stops.
      fill_random(MAX_WORDS);
      run_load(MAX_WORDS, 0, -1);
      check("max_last_addr", 64'(wa_q[wa_q.size()-1]), 64'(MAX_WORDS - 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
